// File: rtl/axi4_pkg.sv
// AXI4 read-channel bundles shared by the instruction-memory responder and its initiators.
package axi4_pkg;

    typedef struct packed {
        logic        arvalid;
        logic [31:0] araddr;
        logic [3:0]  arid;
        logic [7:0]  arlen;
        logic [2:0]  arsize;
        logic [1:0]  arburst;
    } ar_m;

    typedef struct packed {
        logic rready;
    } r_m;

    typedef struct packed {
        logic arready;
    } ar_s;

    typedef struct packed {
        logic        rvalid;
        logic [31:0] rdata;
        logic [3:0]  rid;
        logic [1:0]  rresp;
        logic        rlast;
    } r_s;

endpackage

// File: rtl/riscv_axi_imem.sv
// Read-only AXI4 instruction memory: one burst at a time, 1-cycle first-beat latency,
// with a backdoor word-write port that is only serviced between bursts.
module riscv_axi_imem #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic           clock,
    input  logic           reset,
    input  axi4_pkg::ar_m  AXI_AR_M,
    input  axi4_pkg::r_m   AXI_R_M,
    output axi4_pkg::ar_s  AXI_AR_S,
    output axi4_pkg::r_s   AXI_R_S,
    input  logic           load_vld,
    input  logic [31:0]    load_addr,
    input  logic [31:0]    load_data,
    output logic           load_ack
);

    localparam int IDX_W = $clog2(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t        state;
    logic [31:0]   mem [DEPTH];
    logic [31:0]   addr_q;
    logic [7:0]    len_q;
    logic [1:0]    burst_q;
    logic          slverr_q;
    logic [7:0]    beat_cnt;
    axi4_pkg::r_s  r_q;

    logic          arready;
    logic          ar_fire;
    logic [31:0]   fetch_addr;
    logic          fetch_slverr;
    logic [1:0]    fetch_resp;
    logic [31:0]   fetch_data;

    function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst,
                                              input logic [7:0] len);
        logic [31:0] mask;
        mask = ((32'(len) + 32'd1) << 2) - 32'd1;
        case (burst)
            2'b00:   next_addr = a;
            2'b10:   next_addr = (a & ~mask) | ((a + 32'd4) & mask);
            default: next_addr = a + 32'd4;
        endcase
    endfunction

    // Borrow bit of the 33-bit subtraction flags addresses below the base.
    function automatic logic in_range(input logic [31:0] a);
        logic [32:0] diff;
        diff = {1'b0, a} - {1'b0, BASE_ADDR};
        return !diff[32] && ((diff[31:0] >> 2) < 32'(DEPTH));
    endfunction

    function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
        return IDX_W'((a - BASE_ADDR) >> 2);
    endfunction

    function automatic logic bad_request(input logic [2:0] size, input logic [1:0] burst,
                                         input logic [7:0] len);
        logic wrap_len_ok;
        wrap_len_ok = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        return (size != 3'd2) || (burst == 2'b11) || ((burst == 2'b10) && !wrap_len_ok);
    endfunction

    assign arready          = (state == IDLE) && !load_vld && !reset;
    assign ar_fire          = arready && AXI_AR_M.arvalid;
    assign load_ack         = (state == IDLE) && load_vld && !reset;
    assign AXI_AR_S.arready = arready;
    assign AXI_R_S          = r_q;

    // In IDLE the beat being fetched is the first of the incoming request; in BURST it is the next one.
    always_comb begin
        fetch_addr   = AXI_AR_M.araddr & ~32'h3;
        fetch_slverr = bad_request(AXI_AR_M.arsize, AXI_AR_M.arburst, AXI_AR_M.arlen);
        if (state == BURST) begin
            fetch_addr   = next_addr(addr_q, burst_q, len_q);
            fetch_slverr = slverr_q;
        end
        if (fetch_slverr) begin
            fetch_resp = 2'b10;
        end else if (!in_range(fetch_addr)) begin
            fetch_resp = 2'b11;
        end else begin
            fetch_resp = 2'b00;
        end
        fetch_data = (fetch_resp == 2'b00) ? mem[word_idx(fetch_addr)] : 32'h0;
    end

    always_ff @(posedge clock) begin
        if (load_ack && in_range(load_addr)) begin
            mem[word_idx(load_addr)] <= load_data;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= IDLE;
            beat_cnt <= 8'd0;
            r_q      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ar_fire) begin
                        addr_q     <= fetch_addr;
                        len_q      <= AXI_AR_M.arlen;
                        burst_q    <= AXI_AR_M.arburst;
                        slverr_q   <= fetch_slverr;
                        beat_cnt   <= 8'd0;
                        r_q.rvalid <= 1'b1;
                        r_q.rdata  <= fetch_data;
                        r_q.rid    <= AXI_AR_M.arid;
                        r_q.rresp  <= fetch_resp;
                        r_q.rlast  <= (AXI_AR_M.arlen == 8'd0);
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (AXI_R_M.rready) begin
                        if (beat_cnt == len_q) begin
                            r_q.rvalid <= 1'b0;
                            r_q.rlast  <= 1'b0;
                            state      <= IDLE;
                        end else begin
                            beat_cnt  <= beat_cnt + 8'd1;
                            addr_q    <= fetch_addr;
                            r_q.rdata <= fetch_data;
                            r_q.rresp <= fetch_resp;
                            r_q.rlast <= ((beat_cnt + 8'd1) == len_q);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_axi_imem.sv
// Randomized bench for riscv_axi_imem against a word-array and burst-address reference model.
module tb_riscv_axi_imem;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h0000_0000;

    logic           clock = 1'b0;
    logic           reset;
    axi4_pkg::ar_m  ar_req;
    axi4_pkg::r_m   r_req;
    axi4_pkg::ar_s  ar_rsp;
    axi4_pkg::r_s   r_rsp;
    logic           load_vld;
    logic [31:0]    load_addr;
    logic [31:0]    load_data;
    logic           load_ack;

    riscv_axi_imem #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clock     (clock),
        .reset     (reset),
        .AXI_AR_M  (ar_req),
        .AXI_R_M   (r_req),
        .AXI_AR_S  (ar_rsp),
        .AXI_R_S   (r_rsp),
        .load_vld  (load_vld),
        .load_addr (load_addr),
        .load_data (load_data),
        .load_ack  (load_ack)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
        logic [3:0]  id;
    } beat_t;

    int            errors = 0;
    int            checks = 0;
    logic [31:0]   model_mem [DEPTH];
    beat_t         exp_q [$];
    axi4_pkg::ar_m next_ar;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_mem(input logic [31:0] a);
        longint off;
        off = longint'({32'h0, a}) - longint'({32'h0, BASE});
        return (off >= 0) && (off / 4 < DEPTH);
    endfunction

    function automatic int mem_word(input logic [31:0] a);
        return int'((a - BASE) / 4);
    endfunction

    task automatic expect_burst(input logic [31:0] start, input int len, input int size,
                                input int burst, input logic [3:0] id);
        bit          bad;
        logic [31:0] a0, addr, wsize, wbase;
        beat_t       b;
        bad   = (size != 2) || (burst == 3) ||
                (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
        a0    = start & ~32'h3;
        wsize = 32'((len + 1) * 4);
        wbase = a0 - (a0 % wsize);
        for (int i = 0; i <= len; i++) begin
            case (burst)
                0:       addr = a0;
                2:       addr = wbase + ((a0 - wbase) + 32'(4 * i)) % wsize;
                default: addr = a0 + 32'(4 * i);
            endcase
            b.id   = id;
            b.last = (i == len);
            if (bad) begin
                b.resp = 2'b10; b.data = 32'h0;
            end else if (!in_mem(addr)) begin
                b.resp = 2'b11; b.data = 32'h0;
            end else begin
                b.resp = 2'b00; b.data = model_mem[mem_word(addr)];
            end
            exp_q.push_back(b);
        end
    endtask

    task automatic do_load(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clock);
        ar_req    = '0;
        load_vld  = 1'b1;
        load_addr = addr;
        load_data = data;
        #1;
        check("load_ack", load_ack, 1);
        check("ar_vs_load", ar_rsp.arready, 0);
        @(posedge clock);
        if (in_mem(addr)) model_mem[mem_word(addr)] = data;
    endtask

    task automatic issue_ar(input logic [31:0] start, input int len, input int size,
                            input int burst, input logic [3:0] id);
        int t;
        @(negedge clock);
        load_vld        = 1'b0;
        ar_req.arvalid  = 1'b1;
        ar_req.araddr   = start;
        ar_req.arlen    = 8'(len);
        ar_req.arsize   = 3'(size);
        ar_req.arburst  = 2'(burst);
        ar_req.arid     = id;
        for (t = 0; t < 50; t++) begin
            #1;
            if (ar_rsp.arready) break;
            @(negedge clock);
        end
        check("ar_accept", ar_rsp.arready, 1);
        @(posedge clock);
    endtask

    // mode 0: RREADY always high, 1: toggling 1/0, 2: random
    task automatic collect(input int mode, input bit keep);
        int cyc;
        int maxc;
        bit first;
        cyc   = 0;
        first = 1'b1;
        maxc  = exp_q.size() * 4 + 20;
        while (exp_q.size() > 0 && cyc < maxc) begin
            @(negedge clock);
            if (first) ar_req = keep ? next_ar : '0;
            case (mode)
                0:       r_req.rready = 1'b1;
                1:       r_req.rready = (cyc % 2 == 0);
                default: r_req.rready = 1'($urandom_range(0, 1));
            endcase
            #1;
            check(first ? "first_vld" : "rvalid", r_rsp.rvalid, 1);
            if (r_rsp.rvalid) begin
                check("ar_busy", ar_rsp.arready, 0);
                check("rdata", r_rsp.rdata, exp_q[0].data);
                check("rresp", r_rsp.rresp, exp_q[0].resp);
                check("rlast", r_rsp.rlast, exp_q[0].last);
                check("rid", r_rsp.rid, exp_q[0].id);
                if (r_req.rready) void'(exp_q.pop_front());
            end
            first = 1'b0;
            cyc++;
        end
        check("beats_left", 64'(exp_q.size()), 0);
        exp_q.delete();
        @(negedge clock);
        r_req.rready = 1'($urandom_range(0, 1));
        #1;
        check("vld_after_last", r_rsp.rvalid, 0);
        check("ar_after_last", ar_rsp.arready, 1);
    endtask

    task automatic burst(input logic [31:0] start, input int len, input int size,
                         input int bt, input logic [3:0] id, input int mode);
        issue_ar(start, len, size, bt, id);
        expect_burst(start, len, size, bt, id);
        collect(mode, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        logic [31:0] start;
        int len, size, bt;

        reset     = 1'b1;
        ar_req    = '0;
        r_req     = '0;
        load_vld  = 1'b1;
        load_addr = 32'h0;
        load_data = 32'hA5A5_A5A5;
        repeat (2) @(posedge clock);
        @(negedge clock);
        #1;
        check("rst_arready", ar_rsp.arready, 0);
        check("rst_load_ack", load_ack, 0);
        check("rst_rvalid", r_rsp.rvalid, 0);
        check("rst_rdata", r_rsp.rdata, 0);
        check("rst_rresp", r_rsp.rresp, 0);
        check("rst_rlast", r_rsp.rlast, 0);
        check("rst_rid", r_rsp.rid, 0);
        @(negedge clock);
        reset    = 1'b0;
        load_vld = 1'b0;

        for (int w = 0; w < DEPTH; w++) do_load(BASE + 32'(w * 4), $urandom);
        do_load(32'h0000_1000, 32'hBAD0_BAD0);
        do_load(32'hFFFF_FFFC, 32'hBAD1_BAD1);
        do_load(32'h0000_0301, 32'hCAFE_F00D);
        do_load(32'h0000_0200, 32'h1111_1111);
        do_load(32'h0000_0204, 32'h2222_2222);
        do_load(32'h0000_0208, 32'h3333_3333);
        do_load(32'h0000_020C, 32'h4444_4444);

        burst(32'h200, 3, 2, 1, 4'd5, 0);
        burst(32'h200, 3, 2, 1, 4'd5, 1);
        burst(32'h208, 3, 2, 2, 4'd6, 0);
        burst(32'h208, 2, 2, 2, 4'd7, 0);
        burst(32'hFF8, 3, 2, 1, 4'd8, 1);
        burst(32'h000, 1, 2, 0, 4'd9, 0);
        burst(32'h302, 2, 2, 0, 4'd10, 2);
        burst(32'h200, 1, 1, 1, 4'd11, 0);
        burst(32'h200, 1, 2, 3, 4'd12, 0);
        burst(32'hFFFF_FFF8, 3, 2, 1, 4'd13, 2);

        // load and AR requested together: load wins, AR taken the next cycle
        @(negedge clock);
        load_vld  = 1'b1;
        load_addr = 32'h210;
        load_data = 32'h5555_AAAA;
        ar_req    = '{arvalid: 1'b1, araddr: 32'h210, arid: 4'd3, arlen: 8'd1,
                      arsize: 3'd2, arburst: 2'b01};
        #1;
        check("conf_load_ack", load_ack, 1);
        check("conf_arready", ar_rsp.arready, 0);
        @(posedge clock);
        model_mem[mem_word(32'h210)] = 32'h5555_AAAA;
        @(negedge clock);
        load_vld = 1'b0;
        #1;
        check("conf_ar_next", ar_rsp.arready, 1);
        @(posedge clock);
        expect_burst(32'h210, 1, 2, 1, 4'd3);
        collect(0, 1'b0);

        // AR presented during a burst waits for IDLE
        issue_ar(32'h200, 3, 2, 1, 4'd1);
        expect_burst(32'h200, 3, 2, 1, 4'd1);
        next_ar = '{arvalid: 1'b1, araddr: 32'h300, arid: 4'd2, arlen: 8'd1,
                    arsize: 3'd2, arburst: 2'b01};
        collect(1, 1'b1);
        expect_burst(32'h300, 1, 2, 1, 4'd2);
        collect(2, 1'b0);

        // reset on beat 2 of an 8-beat burst
        issue_ar(32'h100, 7, 2, 1, 4'd4);
        expect_burst(32'h100, 7, 2, 1, 4'd4);
        @(negedge clock);
        ar_req       = '0;
        r_req.rready = 1'b1;
        #1;
        check("mid_beat1", r_rsp.rdata, exp_q[0].data);
        @(negedge clock);
        reset     = 1'b1;
        load_vld  = 1'b1;
        load_addr = 32'h104;
        load_data = 32'hDEAD_BEEF;
        #1;
        check("mid_beat2", r_rsp.rdata, exp_q[1].data);
        check("mid_rst_ar", ar_rsp.arready, 0);
        check("mid_rst_ack", load_ack, 0);
        @(negedge clock);
        reset    = 1'b0;
        load_vld = 1'b0;
        #1;
        check("mid_rvalid", r_rsp.rvalid, 0);
        check("mid_rdata", r_rsp.rdata, 0);
        check("mid_rresp", r_rsp.rresp, 0);
        check("mid_rlast", r_rsp.rlast, 0);
        check("mid_rid", r_rsp.rid, 0);
        check("mid_arready", ar_rsp.arready, 1);
        exp_q.delete();
        burst(32'h100, 7, 2, 1, 4'd4, 2);

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) == 0) do_load(32'($urandom_range(0, 32'h1FFF)), $urandom);
            start = ($urandom_range(0, 9) == 0) ? 32'hFFFF_FFE0 + 32'($urandom_range(0, 31))
                                                 : 32'($urandom_range(0, 32'h1100));
            bt    = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            len   = int'($urandom_range(0, 15));
            if (bt == 2 && $urandom_range(0, 3) != 0) len = (2 << $urandom_range(0, 3)) - 1;
            size  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 7)) : 2;
            burst(start, len, size, bt, 4'($urandom), int'($urandom_range(0, 2)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
